// File: rtl/types.sv
// Shared types for the quick-send receive path: block geometry, the encoded
// header/residual record, the decoded pixel block and the decoder states.
package types;

    localparam int NUM_PIXELS = 16;
    localparam int PIXEL_W    = 8;
    localparam int RW_W       = 4;

    typedef struct packed {
        logic               raw;
        logic [RW_W-1:0]    rw;
        logic [PIXEL_W-1:0] base;
    } header_t;

    // Residual 0 is carried by header_t.base, so the array starts at 1.
    typedef logic [NUM_PIXELS-1:1][PIXEL_W-1:0] residuals_t;

    typedef struct packed {
        header_t    hdr;
        residuals_t res;
    } header_residual_reg;

    typedef logic [NUM_PIXELS-1:0][PIXEL_W-1:0] pixels_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        DONE   = 2'd2
    } dec_state_t;

endpackage

// File: rtl/residual_sext.sv
// Sign-extends the low rw bits of a residual to a full pixel-width delta.
// rw is clamped to PIXEL_W, and rw=0 yields a zero delta.
module residual_sext #(
    parameter int PIXEL_W = 8,
    parameter int RW_W    = 4
) (
    input  logic [PIXEL_W-1:0] res,
    input  logic [RW_W-1:0]    rw,
    output logic [PIXEL_W-1:0] delta
);

    logic [RW_W-1:0] rw_eff;
    logic            sign;

    assign rw_eff = (rw > RW_W'(PIXEL_W)) ? RW_W'(PIXEL_W) : rw;

    always_comb begin
        sign  = 1'b0;
        delta = '0;
        for (int i = 0; i < PIXEL_W; i++) begin
            if (rw_eff == RW_W'(i + 1)) begin
                sign = res[i];
            end
        end
        for (int i = 0; i < PIXEL_W; i++) begin
            delta[i] = (RW_W'(i) < rw_eff) ? res[i] : sign;
        end
    end

endmodule

// File: rtl/header_decoder.sv
// Rebuilds a pixel block from a header/residual record, one pixel per cycle,
// by prefix-summing sign-extended residuals (or copying them in raw mode).
module header_decoder #(
    parameter int NUM_PIXELS = types::NUM_PIXELS,
    parameter int PIXEL_W    = types::PIXEL_W,
    parameter int RW_W       = types::RW_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [1+RW_W+NUM_PIXELS*PIXEL_W-1:0] hr_reg,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_PIXELS*PIXEL_W-1:0]   pixels,
    output logic                            bad_hdr,
    output logic                            busy
);
    import types::*;

    localparam int IDX_W = $clog2(NUM_PIXELS);

    header_residual_reg hr_rec;

    dec_state_t          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                raw_q, raw_d;
    logic [RW_W-1:0]     rw_q, rw_d;
    residuals_t          res_q, res_d;
    pixels_t             pix_q, pix_d;
    logic                bad_q, bad_d;

    logic [PIXEL_W-1:0]  cur_res;
    logic [PIXEL_W-1:0]  prev_pix;
    logic [PIXEL_W-1:0]  delta;

    assign hr_rec   = hr_reg;
    assign cur_res  = res_q[idx_q];
    assign prev_pix = pix_q[idx_q - 1'b1];

    residual_sext #(
        .PIXEL_W (PIXEL_W),
        .RW_W    (RW_W)
    ) u_sext (
        .res   (cur_res),
        .rw    (rw_q),
        .delta (delta)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        raw_d   = raw_q;
        rw_d    = rw_q;
        res_d   = res_q;
        pix_d   = pix_q;
        bad_d   = bad_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    raw_d    = hr_rec.hdr.raw;
                    rw_d     = hr_rec.hdr.rw;
                    res_d    = hr_rec.res;
                    pix_d    = '0;
                    pix_d[0] = hr_rec.hdr.base;
                    bad_d    = (hr_rec.hdr.rw > RW_W'(PIXEL_W));
                    idx_d    = IDX_W'(1);
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                pix_d[idx_q] = raw_q ? cur_res : (prev_pix + delta);
                idx_d        = idx_q + 1'b1;
                if (idx_q == IDX_W'(NUM_PIXELS - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Result and bad_hdr are held until the consumer takes them.
                if (out_ready) begin
                    bad_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            raw_q   <= 1'b0;
            rw_q    <= '0;
            res_q   <= '0;
            pix_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            raw_q   <= raw_d;
            rw_q    <= rw_d;
            res_q   <= res_d;
            pix_q   <= pix_d;
            bad_q   <= bad_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    // Partially decoded blocks never reach the port.
    assign pixels    = out_valid ? pix_q : '0;
    assign bad_hdr   = bad_q;

endmodule

// File: tb/tb_header_decoder.sv
// Directed bench for header_decoder: table of blocks with hand-derived pixels,
// plus backpressure and mid-decode reset sequences.
module tb_header_decoder;
    import types::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid;
    logic         in_ready;
    logic [132:0] hr_reg;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pixels;
    logic         bad_hdr;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    header_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hr_reg    (hr_reg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pixels    (pixels),
        .bad_hdr   (bad_hdr),
        .busy      (busy)
    );

    typedef struct {
        logic       raw;
        logic [3:0] rw;
        logic [7:0] base;
        logic [7:0] res [16];
        logic [7:0] exp_pix [16];
        logic       exp_bad;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [132:0] pack_rec(input vec_t v);
        header_residual_reg r;
        r.hdr.raw  = v.raw;
        r.hdr.rw   = v.rw;
        r.hdr.base = v.base;
        for (int i = 1; i < 16; i++) r.res[i] = v.res[i];
        return r;
    endfunction

    function automatic logic [127:0] exp_block(input vec_t v);
        logic [127:0] p;
        for (int i = 0; i < 16; i++) p[i*8 +: 8] = v.exp_pix[i];
        return p;
    endfunction

    task automatic accept(input int k);
        @(negedge clk);
        check("in_ready_before_accept", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        hr_reg   = pack_rec(vecs[k]);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hr_reg   = 133'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    task automatic wait_done(input string nm);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, "_latency"}, 128'(lat), 128'd15);
    endtask

    task automatic release_block(input string nm);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({nm, "_out_valid_cleared"}, 128'(out_valid), 128'd0);
        check({nm, "_bad_hdr_cleared"}, 128'(bad_hdr), 128'd0);
        check({nm, "_in_ready_back"}, 128'(in_ready), 128'd1);
    endtask

    task automatic run_vec(input int k);
        string nm;
        nm = $sformatf("vec%0d", k);
        accept(k);
        check({nm, "_busy"}, 128'(busy), 128'd1);
        wait_done(nm);
        check({nm, "_pixels"}, pixels, exp_block(vecs[k]));
        check({nm, "_bad_hdr"}, 128'(bad_hdr), 128'(vecs[k].exp_bad));
        check({nm, "_in_ready_done"}, 128'(in_ready), 128'd0);
        release_block(nm);
    endtask

    initial begin
        logic [127:0] held;

        // flat: rw=0 ignores residual contents
        vecs[0].raw = 1'b0; vecs[0].rw = 4'd0; vecs[0].base = 8'h40; vecs[0].exp_bad = 1'b0;
        // ramp up across the 0xFF wrap
        vecs[1].raw = 1'b0; vecs[1].rw = 4'd2; vecs[1].base = 8'hFE; vecs[1].exp_bad = 1'b0;
        // ramp down, residual high bits are junk
        vecs[2].raw = 1'b0; vecs[2].rw = 4'd2; vecs[2].base = 8'h00; vecs[2].exp_bad = 1'b0;
        // raw mode copies residuals verbatim
        vecs[3].raw = 1'b1; vecs[3].rw = 4'd3; vecs[3].base = 8'h10; vecs[3].exp_bad = 1'b0;
        // rw=9 clamps to 8
        vecs[4].raw = 1'b0; vecs[4].rw = 4'd9; vecs[4].base = 8'h05; vecs[4].exp_bad = 1'b1;
        // rw=4, residual 0xE7 -> +7
        vecs[5].raw = 1'b0; vecs[5].rw = 4'd4; vecs[5].base = 8'h80; vecs[5].exp_bad = 1'b0;
        // rw=3, residual 100b -> -4
        vecs[6].raw = 1'b0; vecs[6].rw = 4'd3; vecs[6].base = 8'h20; vecs[6].exp_bad = 1'b0;
        // rw=8 exactly, full-width residual 0x81
        vecs[7].raw = 1'b0; vecs[7].rw = 4'd8; vecs[7].base = 8'h00; vecs[7].exp_bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            vecs[0].res[i] = 8'hA5; vecs[0].exp_pix[i] = 8'h40;
            vecs[1].res[i] = 8'h01; vecs[1].exp_pix[i] = 8'(254 + i);
            vecs[2].res[i] = 8'hFB; vecs[2].exp_pix[i] = 8'(0 - i);
            vecs[3].res[i] = 8'(i * 3); vecs[3].exp_pix[i] = (i == 0) ? 8'h10 : 8'(i * 3);
            vecs[4].res[i] = 8'hFF; vecs[4].exp_pix[i] = 8'(5 - i);
            vecs[5].res[i] = 8'hE7; vecs[5].exp_pix[i] = 8'(128 + 7 * i);
            vecs[6].res[i] = 8'h04; vecs[6].exp_pix[i] = 8'(32 - 4 * i);
            vecs[7].res[i] = 8'h81; vecs[7].exp_pix[i] = 8'(i * 129);
        end

        in_valid  = 1'b0;
        out_ready = 1'b0;
        hr_reg    = '0;
        #1;
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_pixels", pixels, 128'd0);
        check("reset_bad_hdr", 128'(bad_hdr), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_in_ready", 128'(in_ready), 128'd1);

        // out_ready in IDLE must not start anything
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_out_ready_busy", 128'(busy), 128'd0);
        check("idle_out_ready_valid", 128'(out_valid), 128'd0);

        for (int k = 0; k < 8; k++) run_vec(k);

        // backpressure: hold result, offer a new record meanwhile
        accept(1);
        wait_done("bp");
        held = exp_block(vecs[1]);
        for (int c = 0; c < 20; c++) begin
            if (c >= 5) begin
                in_valid = 1'b1;
                hr_reg   = pack_rec(vecs[0]);
            end
            @(posedge clk);
            #1;
            check("bp_pixels_stable", pixels, held);
            check("bp_in_ready_low", 128'(in_ready), 128'd0);
            check("bp_out_valid_held", 128'(out_valid), 128'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_handshake_valid", 128'(out_valid), 128'd0);
        check("bp_not_taken_yet", 128'(busy), 128'd0);
        check("bp_in_ready_after", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hr_reg   = '0;
        check("bp_taken_busy", 128'(busy), 128'd1);
        check("bp_taken_in_ready", 128'(in_ready), 128'd0);
        wait_done("bp_second");
        check("bp_second_pixels", pixels, exp_block(vecs[0]));
        release_block("bp_second");

        // reset while idx=7 is about to be written
        accept(4);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_out_valid", 128'(out_valid), 128'd0);
        check("rst_mid_busy", 128'(busy), 128'd0);
        check("rst_mid_pixels", pixels, 128'd0);
        check("rst_mid_bad_hdr", 128'(bad_hdr), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", 128'(in_ready), 128'd1);
        run_vec(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/header_decoder.md
Name: header_decoder

Overview:
- Inverse of the header/residual encoder: accepts one `types::header_residual_reg` record and reconstructs the original `types::pixels_t` block.
- Sits on the receive side of quick-send, after the link deframer and ahead of the frame buffer write port.
- Reconstructs one pixel per cycle using an iterative prefix-sum, with valid/ready handshakes on both sides.

Parameters:
- NUM_PIXELS, 16, pixels per block; must equal `types::NUM_PIXELS`.
- PIXEL_W, 8, bits per pixel; must equal `types::PIXEL_W`.
- RW_W, 4, width of the residual-width code field.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  hr_reg holds a valid record
- in_ready  out  1  decoder can accept a record
- hr_reg  in  $bits(types::header_residual_reg) = 1+RW_W+NUM_PIXELS*PIXEL_W (133)  encoded block: {raw, rw, base, res[1..NUM_PIXELS-1]}
- out_valid  out  1  pixels holds a complete decoded block
- out_ready  in  1  consumer accepts pixels
- pixels  out  NUM_PIXELS*PIXEL_W  decoded block, pixel 0 in the least-significant field
- bad_hdr  out  1  the block currently presented had rw > PIXEL_W
- busy  out  1  FSM not IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; idx=0.
  - out_valid=0, bad_hdr=0, busy=0, pixels=0; in_ready=1 after reset release.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register hr_reg into the record latch, write pix[0]=base, set idx=1, latch bad_hdr=(rw>PIXEL_W), go to DECODE.
- FSM DECODE:
  - in_ready=0.
  - Each cycle writes pix[idx], then idx++.
  - raw=1: pix[idx]=res[idx] verbatim.
  - raw=0: pix[idx]=pix[idx-1]+sext(res[idx][rw_eff-1:0]), modulo 2^PIXEL_W (wrap, no saturation).
  - rw_eff = min(rw, PIXEL_W). rw=0 means all residuals are 0 (flat block). Bits of res above rw_eff are ignored.
  - When idx==NUM_PIXELS-1 is written, go to DONE.
- FSM DONE:
  - out_valid=1; pixels and bad_hdr are stable while out_valid && !out_ready.
  - On out_ready: out_valid=0 next cycle, go to IDLE, and clear bad_hdr.
- Latency: record accepted at edge T -> out_valid high from edge T+NUM_PIXELS-1 (15 cycles for defaults). Throughput is one block per NUM_PIXELS cycles plus the output handshake.
- in_ready depends only on state (registered). It is never combinationally dependent on out_ready; there is no accept-while-DONE overlap.
- hr_reg may change freely after acceptance because the record is latched.
- in_valid during DECODE or DONE is ignored; the upstream holds it.
- out_ready while out_valid=0 has no effect.
- Async reset mid-DECODE or mid-DONE aborts the block; no partial output is ever presented.
- busy=1 in DECODE and DONE.

Decomposition:
- `types` package gains:
  - constants NUM_PIXELS, PIXEL_W, RW_W
  - `header_t` {raw, rw, base}
  - `header_residual_reg` {header_t, residual array}
  - `pixels_t` as a packed array of PIXEL_W-bit pixels
  - enum `dec_state_t` {IDLE, DECODE, DONE}
- One combinational sub-module, `residual_sext`:
  - inputs: res[PIXEL_W], rw[RW_W]
  - output: sign-extended PIXEL_W-bit delta with clamping to PIXEL_W.
  - Shared with a later encoder self-check.

Test Plan:
- Flat block: raw=0, rw=0, base=0x40 -> all 16 pixels 0x40; out_valid at T+15; bad_hdr=0.
- Ramp with wrap: raw=0, rw=2, base=0xFE, all residuals=01b -> pixels FE,FF,00,01,...,0D.
  - Second case: residual 11b (=-1) from base 0x00 -> 00,FF,FE,...
- Raw mode: raw=1, res[i]=i*3 (with res[0] as base=0x10) -> pixels[0]=0x10, pixels[i]=i*3 exactly; residual high bits not masked.
- Bad header: rw=9, res=0xFF each, base=0x05 -> treated as rw=8 (delta -1): 05,04,...,F6; bad_hdr=1 while out_valid, cleared after out_ready.
- Backpressure: hold out_ready=0 for 20 cycles in DONE and pulse in_valid with a new record -> pixels stable, in_ready=0, new record not taken until one cycle after out_ready handshake.
- Reset mid-DECODE: assert rst=0 at idx=7 -> out_valid, busy, pixels go to 0 immediately (asynchronously); after release, in_ready=1 and the next record decodes correctly.
